serial_tx: RTL and testbench

- Parallel-in, serial-out transmitter. Drives the single-bit serial line sampled by the team's D flip-flop capture stage.
- Accepts a WIDTH-bit word over a valid/ready handshake. Emits one frame: start bit, data bits LSB-first, optional even parity bit, stop bit.
- Each bit is held for CLKS_PER_BIT clocks.
- Sits between a parallel producer and the serial link.

---
 rtl/serial_tx.sv | 115 +++++++++++
 tb/tb_serial_tx.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// Parallel-in, serial-out transmitter: start bit, LSB-first data, optional even
// parity, stop bit, each held for CLKS_PER_BIT clocks. Idle line level is 1.
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] BIT_ONE   = CW'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [CW-1:0]    bit_cnt_reg;
    logic [BW-1:0]    baud_cnt_reg;
    logic             parity_reg;
    logic             baud_last;

    assign baud_last  = (baud_cnt_reg == BAUD_LAST);
    assign shift_next = shift_reg >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            baud_cnt_reg <= '0;
            parity_reg   <= 1'b0;
            tx           <= 1'b1;
            ready_out    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            // Baud counter only runs while a frame is on the line.
            if (state_reg != IDLE) begin
                baud_cnt_reg <= baud_last ? '0 : baud_cnt_reg + BAUD_ONE;
            end
            case (state_reg)
                IDLE: begin
                    if (valid_in && ready_out) begin
                        shift_reg    <= data_in;
                        parity_reg   <= ^data_in;
                        bit_cnt_reg  <= '0;
                        baud_cnt_reg <= '0;
                        state_reg    <= START;
                        busy         <= 1'b1;
                        ready_out    <= 1'b0;
                        tx           <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        state_reg <= DATA;
                        tx        <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        if (bit_cnt_reg == BIT_LAST) begin
                            if (PARITY_EN != 0) begin
                                state_reg <= PARITY;
                                tx        <= parity_reg;
                            end else begin
                                state_reg <= STOP;
                                tx        <= 1'b1;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BIT_ONE;
                            shift_reg   <= shift_next;
                            tx          <= shift_next[0];
                        end
                    end
                end
                PARITY: begin
                    if (baud_last) begin
                        state_reg <= STOP;
                        tx        <= 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        ready_out <= 1'b1;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx        <= 1'b1;
                    busy      <= 1'b0;
                    ready_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: three instances cover the default framing,
// the even-parity variant and the one-clock-per-bit variant.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    int         sel = 0;
    int         checks = 0;
    int         failures = 0;

    logic valid_a, ready_a, tx_a, busy_a, done_a;
    logic valid_p, ready_p, tx_p, busy_p, done_p;
    logic valid_f, ready_f, tx_f, busy_f, done_f;
    logic [3:0] obs;   // {tx, ready_out, busy, done} of the selected instance

    always #5 clk = ~clk;

    assign valid_a = valid && (sel == 0);
    assign valid_p = valid && (sel == 1);
    assign valid_f = valid && (sel == 2);

    always_comb begin
        obs = {tx_a, ready_a, busy_a, done_a};
        case (sel)
            1:       obs = {tx_p, ready_p, busy_p, done_p};
            2:       obs = {tx_f, ready_f, busy_f, done_f};
            default: obs = {tx_a, ready_a, busy_a, done_a};
        endcase
    end

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(data), .valid_in(valid_a),
        .ready_out(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a));
    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_p (
        .clk(clk), .rst_n(rst_n), .data_in(data), .valid_in(valid_p),
        .ready_out(ready_p), .tx(tx_p), .busy(busy_p), .done(done_p));
    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_f (
        .clk(clk), .rst_n(rst_n), .data_in(data), .valid_in(valid_f),
        .ready_out(ready_f), .tx(tx_f), .busy(busy_f), .done(done_f));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Expected bit for period p is exp[p]; every cycle of the frame is checked.
    task automatic check_bits(input logic [10:0] exp, input int nbits, input int cpb, input string tag);
        for (int p = 0; p < nbits; p++) begin
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                check_eq($sformatf("%s_bit%0d_c%0d", tag, p, c), {28'd0, obs}, {28'd0, exp[p], 3'b010});
            end
        end
    endtask

    task automatic check_done(input string tag);
        @(negedge clk);
        check_eq({tag, "_done"}, {28'd0, obs}, 32'hD);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [10:0] exp, input int nbits,
                             input int cpb, input string tag);
        @(negedge clk);
        check_eq({tag, "_ready"}, {28'd0, obs}, 32'hC);
        data  = d;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        check_bits(exp, nbits, cpb, tag);
        check_done(tag);
        @(negedge clk);
        check_eq({tag, "_idle"}, {28'd0, obs}, 32'hC);
        $display("frame %s data=0x%02h checked", tag, d);
    endtask

    initial begin
        // Reset state and quiet idle line
        #12;
        check_eq("reset_obs", {28'd0, obs}, 32'hC);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq($sformatf("idle_c%0d", i), {28'd0, obs}, 32'hC);
        end
        $display("idle 20 cycles checked");

        // Basic frame, 40 cycles
        sel = 0;
        run_frame(8'hA5, 11'b00_1101001010, 10, 4, "a5");

        // Even parity
        sel = 1;
        run_frame(8'h07, 11'b11000001110, 11, 4, "par07");
        run_frame(8'hA5, 11'b10101001010, 11, 4, "parA5");

        // valid held, data changed mid-frame, back-to-back acceptance on done cycle
        sel = 0;
        @(negedge clk);
        data  = 8'h3C;
        valid = 1'b1;
        @(posedge clk);
        #1 data = 8'hFF;
        check_bits(11'b00_1001111000, 10, 4, "b2b3C");
        check_done("b2b3C");
        @(posedge clk);
        #1 valid = 1'b0;
        check_bits(11'b00_1111111110, 10, 4, "b2bFF");
        check_done("b2bFF");
        $display("back-to-back 0x3C/0xFF checked");

        // Asynchronous reset during data bit 3
        @(negedge clk);
        data  = 8'hA5;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (17) @(posedge clk);
        #1 check_eq("pre_rst_tx", {31'd0, tx_a}, 32'd0);
        #1 rst_n = 1'b0;
        #1 check_eq("async_rst", {28'd0, obs}, 32'hC);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq($sformatf("in_rst_c%0d", i), {28'd0, obs}, 32'hC);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst", {28'd0, obs}, 32'hC);
        $display("mid-frame reset checked");
        run_frame(8'h55, 11'b00_1010101010, 10, 4, "r55");

        // One clock per bit
        sel = 2;
        run_frame(8'h81, 11'b00_1100000010, 10, 1, "fast81");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
